// File: rtl/snn_sched_pkg.sv
// Shared helpers for the spike scheduler: packet field extraction, ring arithmetic, error bit indices.
package snn_sched_pkg;

  localparam int unsigned ERR_DUP   = 0;
  localparam int unsigned ERR_RANGE = 1;

  // Packet layout is {delay, axon}; axon occupies the low axon_w bits.
  function automatic int unsigned get_axon(logic [63:0] pkt, int unsigned axon_w);
    return 32'(pkt & ((64'd1 << axon_w) - 64'd1));
  endfunction

  function automatic int unsigned get_delay(logic [63:0] pkt, int unsigned axon_w);
    return 32'(pkt >> axon_w);
  endfunction

  // (ptr + delay) mod num_slots for ptr, delay < num_slots: one conditional subtract.
  function automatic int unsigned ring_add(int unsigned ptr, int unsigned delay,
                                           int unsigned num_slots);
    int unsigned sum;
    sum = ptr + delay;
    return (sum >= num_slots) ? sum - num_slots : sum;
  endfunction

endpackage

// File: rtl/spike_slot_ring.sv
// Delay ring storage: NUM_SLOTS rows of NUM_AXONS spike bits, read pointer, clear-on-advance, bit-set port.
module spike_slot_ring #(
  parameter int unsigned NUM_AXONS = 256,
  parameter int unsigned NUM_SLOTS = 16,
  localparam int unsigned AXON_W  = $clog2(NUM_AXONS),
  localparam int unsigned DELAY_W = $clog2(NUM_SLOTS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 adv,
  input  logic                 set_en,
  input  logic [DELAY_W-1:0]   set_row,
  input  logic [AXON_W-1:0]    set_axon,
  output logic [DELAY_W-1:0]   rd_ptr,
  output logic [NUM_AXONS-1:0] rd_row_c,
  output logic                 set_hit_c
);

  logic [NUM_AXONS-1:0] rows [NUM_SLOTS];

  assign rd_row_c  = rows[rd_ptr];
  assign set_hit_c = rows[set_row][set_axon];

  // Row being emitted is cleared; the caller never sets a bit in the row it advances past.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < int'(NUM_SLOTS); r++) rows[r] <= '0;
    end else begin
      for (int r = 0; r < int'(NUM_SLOTS); r++) begin
        if (flush) begin
          rows[r] <= '0;
        end else if (adv && (rd_ptr == DELAY_W'(r))) begin
          rows[r] <= '0;
        end else if (set_en && (set_row == DELAY_W'(r))) begin
          rows[r] <= rows[r] | (NUM_AXONS'(1) << set_axon);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
    end else if (adv) begin
      rd_ptr <= (rd_ptr == DELAY_W'(NUM_SLOTS - 1)) ? '0 : rd_ptr + DELAY_W'(1);
    end
  end

endmodule

// File: rtl/spike_scheduler_param.sv
// Parametrised axon spike scheduler: delay ring with range/duplicate detection, flush and valid strobe.
// Optional macro SCHED_PENDING_CNT_EN adds pending_count (total set bits across the ring).
module spike_scheduler_param
  import snn_sched_pkg::*;
#(
  parameter int unsigned NUM_AXONS = 256,
  parameter int unsigned NUM_SLOTS = 16,
  localparam int unsigned AXON_W  = $clog2(NUM_AXONS),
  localparam int unsigned DELAY_W = $clog2(NUM_SLOTS),
  localparam int unsigned PKT_W   = DELAY_W + AXON_W,
  localparam int unsigned CNT_W   = $clog2(NUM_SLOTS * NUM_AXONS + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 wen,
  input  logic [PKT_W-1:0]     packet,
  input  logic                 tick_adv,
  input  logic                 flush,
  input  logic                 err_clr,
  output logic [NUM_AXONS-1:0] axon_spikes,
  output logic                 spikes_valid,
  output logic [1:0]           error
`ifdef SCHED_PENDING_CNT_EN
  ,
  output logic [CNT_W-1:0]     pending_count
`endif
);

  logic [DELAY_W-1:0]   pkt_delay;
  logic [AXON_W-1:0]    pkt_axon;
  logic [DELAY_W-1:0]   target_row;
  logic [DELAY_W-1:0]   rd_ptr;
  logic [NUM_AXONS-1:0] rd_row_c;
  logic                 set_hit_c;
  logic                 range_err_c;
  logic                 wr_ok_c;
  logic                 merge_c;
  logic                 set_en_c;
  logic                 dup_c;
  logic [NUM_AXONS-1:0] merge_vec_c;
  logic [1:0]           new_err_c;

  // Decode, classify and route the incoming packet.
  always_comb begin
    pkt_delay   = DELAY_W'(get_delay(64'(packet), AXON_W));
    pkt_axon    = AXON_W'(get_axon(64'(packet), AXON_W));
    range_err_c = wen && !flush &&
                  ((32'(pkt_axon) >= NUM_AXONS) || (32'(pkt_delay) >= NUM_SLOTS));
    wr_ok_c     = wen && !flush && !range_err_c;
    target_row  = DELAY_W'(ring_add(32'(rd_ptr), 32'(pkt_delay), NUM_SLOTS));
    merge_c     = wr_ok_c && tick_adv && (target_row == rd_ptr);
    set_en_c    = wr_ok_c && !merge_c;
    dup_c       = set_en_c && set_hit_c;
    merge_vec_c = merge_c ? (NUM_AXONS'(1) << pkt_axon) : '0;
    new_err_c   = '0;
    new_err_c[ERR_DUP]   = dup_c;
    new_err_c[ERR_RANGE] = range_err_c;
  end

  spike_slot_ring #(
    .NUM_AXONS (NUM_AXONS),
    .NUM_SLOTS (NUM_SLOTS)
  ) u_ring (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .adv       (tick_adv),
    .set_en    (set_en_c),
    .set_row   (target_row),
    .set_axon  (pkt_axon),
    .rd_ptr    (rd_ptr),
    .rd_row_c  (rd_row_c),
    .set_hit_c (set_hit_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      axon_spikes  <= '0;
      spikes_valid <= 1'b0;
    end else if (flush) begin
      axon_spikes  <= '0;
      spikes_valid <= 1'b0;
    end else begin
      spikes_valid <= tick_adv;
      if (tick_adv) axon_spikes <= rd_row_c | merge_vec_c;
    end
  end

  // Sticky errors; a new error in the clear cycle survives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error <= 2'b00;
    end else begin
      error <= (err_clr ? 2'b00 : error) | new_err_c;
    end
  end

`ifdef SCHED_PENDING_CNT_EN
  logic [CNT_W-1:0] cnt_inc_c;
  logic [CNT_W-1:0] cnt_dec_c;

  always_comb begin
    cnt_inc_c = CNT_W'(set_en_c && !dup_c);
    cnt_dec_c = tick_adv ? CNT_W'($countones(rd_row_c)) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_count <= '0;
    end else if (flush) begin
      pending_count <= '0;
    end else begin
      pending_count <= pending_count + cnt_inc_c - cnt_dec_c;
    end
  end
`endif

endmodule

// File: tb/tb_spike_scheduler_param.sv
// Scoreboard bench for spike_scheduler_param (NUM_AXONS=200, NUM_SLOTS=10) against an absolute-tick event model.
module tb_spike_scheduler_param;

  localparam int NA = 200;
  localparam int NS = 10;
  localparam int AW = $clog2(NA);
  localparam int DW = $clog2(NS);
  localparam int PW = AW + DW;
  localparam int CW = $clog2(NA * NS + 1);

  logic          clk;
  logic          reset_n;
  logic          wen;
  logic [PW-1:0] packet;
  logic          tick_adv;
  logic          flush;
  logic          err_clr;
  logic [NA-1:0] axon_spikes;
  logic          spikes_valid;
  logic [1:0]    error;
`ifdef SCHED_PENDING_CNT_EN
  logic [CW-1:0] pending_count;
`endif

  spike_scheduler_param #(.NUM_AXONS(NA), .NUM_SLOTS(NS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wen          (wen),
    .packet       (packet),
    .tick_adv     (tick_adv),
    .flush        (flush),
    .err_clr      (err_clr),
    .axon_spikes  (axon_spikes),
    .spikes_valid (spikes_valid),
    .error        (error)
`ifdef SCHED_PENDING_CNT_EN
    ,
    .pending_count(pending_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: each pending spike remembers the absolute tick number that delivers it.
  typedef struct { int due; int axon; } ev_t;
  ev_t           evq[$];
  logic [NA-1:0] exp_q[$];
  int            ticks;
  logic [1:0]    m_err;
  bit            m_valid;
  bit            mon_en;
  int            n_checks;
  int            n_fail;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    evq.delete();
    ticks   = 0;
    m_err   = 2'b00;
    m_valid = 1'b0;
  endtask

  task automatic step(input bit w, input int d, input int a, input bit tk, input bit f, input bit c);
    logic [NA-1:0] vec;
    logic [1:0]    nerr;
    bit            exists;
    int            due;
    @(negedge clk);
    wen      = w;
    packet   = {DW'(d), AW'(a)};
    tick_adv = tk;
    flush    = f;
    err_clr  = c;
    nerr = c ? 2'b00 : m_err;
    if (f) begin
      evq.delete();
    end else begin
      if (w) begin
        if (a >= NA || d >= NS) begin
          nerr[1] = 1'b1;
        end else begin
          due = ticks + d + 1;
          exists = 1'b0;
          foreach (evq[i]) if (evq[i].due == due && evq[i].axon == a) exists = 1'b1;
          // A spike landing in the row being emitted merges into the output, never a duplicate.
          if (exists && !(tk && d == 0)) nerr[0] = 1'b1;
          if (!exists) evq.push_back('{due, a});
        end
      end
      if (tk) begin
        vec = '0;
        for (int i = evq.size() - 1; i >= 0; i--) begin
          if (evq[i].due == ticks + 1) begin
            vec[evq[i].axon] = 1'b1;
            evq.delete(i);
          end
        end
        ticks++;
        exp_q.push_back(vec);
      end
    end
    m_err   = nerr;
    m_valid = tk && !f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0);
  endtask

  // Monitor: compares every cycle just after the active edge.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      chk("spikes_valid", 256'(spikes_valid), 256'(m_valid));
      chk("error", 256'(error), 256'(m_err));
`ifdef SCHED_PENDING_CNT_EN
      chk("pending_count", 256'(pending_count), 256'(evq.size()));
`endif
      if (spikes_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 256'(1), 256'(0));
        end else begin
          chk("axon_spikes", 256'(axon_spikes), 256'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    reset_n  = 1'b0;
    wen = 1'b0; packet = '0; tick_adv = 1'b0; flush = 1'b0; err_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_axon_spikes", 256'(axon_spikes), 256'(0));
    chk("reset_valid", 256'(spikes_valid), 256'(0));
    chk("reset_error", 256'(error), 256'(0));
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Delay 3: only the 4th tick delivers axon 5.
    step(1, 3, 5, 0, 0, 0);
    ticks_n(4);
    idle(1);

    // Wrap: rd_ptr 8 plus delay 5 lands in row 3, seen on the 6th tick.
    step(0, 0, 0, 0, 1, 0);
    ticks_n(8);
    step(1, 5, 17, 0, 0, 0);
    ticks_n(6);
    idle(1);

    // Duplicate, then clear.
    step(1, 0, 7, 0, 0, 0);
    step(1, 0, 7, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    idle(1);

    // Range violations on axon and on delay.
    step(1, 0, 250, 0, 0, 0);
    step(1, 12, 3, 0, 0, 0);
    ticks_n(NS + 1);
    step(0, 0, 0, 0, 0, 1);

    // Merge: write to current row together with tick.
    step(1, 0, 9, 1, 0, 0);
    ticks_n(1);
    idle(1);

    // Flush with concurrent write and tick.
    step(1, 1, 11, 0, 0, 0);
    step(1, 2, 12, 0, 0, 0);
    step(1, 3, 13, 0, 0, 0);
    step(1, 0, 4, 1, 1, 0);
    @(posedge clk);
    #2;
    chk("flush_axon_spikes", 256'(axon_spikes), 256'(0));
    ticks_n(NS);
    idle(1);

    // Reset mid-operation discards pending spikes.
    step(1, 2, 20, 0, 0, 0);
    step(1, 4, 30, 1, 0, 0);
    @(negedge clk);
    wen = 1'b0; tick_adv = 1'b0; flush = 1'b0; err_clr = 1'b0;
    reset_n = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    chk("midreset_axon_spikes", 256'(axon_spikes), 256'(0));
    @(negedge clk);
    reset_n = 1'b1;
    ticks_n(NS);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int d, a;
      bit w, tk, f, c;
      w  = ($urandom_range(0, 99) < 60);
      d  = $urandom_range(0, 11);
      if ($urandom_range(0, 1) == 1) a = $urandom_range(0, 7);
      else if ($urandom_range(0, 9) == 0) a = $urandom_range(NA, 255);
      else a = $urandom_range(0, NA - 1);
      tk = ($urandom_range(0, 99) < 35);
      f  = ($urandom_range(0, 99) < 2);
      c  = ($urandom_range(0, 99) < 6);
      step(w, d, a, tk, f, c);
    end
    ticks_n(NS);
    idle(2);

    chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_scheduler_param.md
Name: spike_scheduler_param

Overview:
- Parametrised successor to the fixed 256-axon / 16-tick core scheduler.
- Buffers incoming axon spike packets from the router's local port into a delay ring of NUM_SLOTS time slots. On each tick-advance it presents one slot's NUM_AXONS-bit spike vector to the neuron grid.
- New behaviour over the previous generation:
  - width and depth are generic;
  - out-of-range packets are detected;
  - duplicate spikes are detected;
  - a whole-buffer flush exists;
  - a single-cycle output valid strobe accompanies each slot.

Parameters:
- NUM_AXONS, 256, number of axons (bits per slot); any value ≥2.
- NUM_SLOTS, 16, delay depth in ticks; any value ≥2, need not be a power of 2.
- AXON_W, $clog2(NUM_AXONS), axon index field width (derived, not overridden).
- DELAY_W, $clog2(NUM_SLOTS), delay field width (derived, not overridden).

Ports:
- clk  in  1  core clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- wen  in  1  packet write strobe from router local output.
- packet  in  DELAY_W+AXON_W  {delay[DELAY_W-1:0], axon[AXON_W-1:0]}.
- tick_adv  in  1  one-cycle pulse: emit current slot, advance ring.
- flush  in  1  one-cycle pulse: clear all slots.
- err_clr  in  1  clears sticky error bits.
- axon_spikes  out  NUM_AXONS  registered spike vector for neuron grid.
- spikes_valid  out  1  one-cycle strobe, axon_spikes updated.
- error  out  2  sticky: [0] duplicate spike, [1] range violation.

Behaviour:
- Clock and reset: one clock, clk. Reset reset_n is asynchronous, active-low.
- Reset values: all slots 0, rd_ptr 0, axon_spikes 0, spikes_valid 0, error 2'b00. Reset mid-operation discards all pending spikes.
- Storage: NUM_SLOTS rows × NUM_AXONS bits; rd_ptr in [0, NUM_SLOTS-1].
- Write target: on wen, the target row is (rd_ptr + delay) mod NUM_SLOTS. The modulo is computed in DELAY_W+1 bits with a conditional subtract, no divider. The target bit is set the next cycle.
- Delivery latency: delay=0 is delivered on the next tick_adv; delay=d on the (d+1)th tick_adv.
- Range check: if axon ≥ NUM_AXONS or delay ≥ NUM_SLOTS, the packet is dropped and error[1] is set.
- Duplicate: if the target bit is already 1, error[0] is set. The bit stays 1 (idempotent).
- tick_adv, cycle N:
  - axon_spikes <= row[rd_ptr];
  - row[rd_ptr] <= 0;
  - rd_ptr <= rd_ptr+1, wrapping NUM_SLOTS-1 → 0;
  - spikes_valid=1 in cycle N+1 only.
- Simultaneous wen + tick_adv with target row == rd_ptr: the spike is ORed into the captured axon_spikes, is not left in the cleared row, and does not raise a duplicate error.
- Simultaneous wen + tick_adv to any other row: both take effect normally.
- flush, highest priority:
  - all rows 0, rd_ptr 0, axon_spikes 0, spikes_valid 0;
  - a concurrent wen and tick_adv in the same cycle are discarded;
  - error is not affected.
- err_clr: clears error the next cycle. A new error flagged in the same cycle wins (set over clear).
- Back-to-back wen every cycle is supported; there is no backpressure.

Optional Feature:
- Macro SCHED_PENDING_CNT_EN.
- Defined:
  - adds output pending_count, width $clog2(NUM_SLOTS*NUM_AXONS+1);
  - it holds the total number of set bits across all rows;
  - +1 per accepted non-duplicate write;
  - minus popcount(row[rd_ptr]) on tick_adv;
  - 0 on flush and on reset;
  - the merged same-row case nets to 0.
- Undefined: the port and its counter logic are absent.

Decomposition:
- Package snn_sched_pkg holds:
  - a packet field-extraction function (delay, axon);
  - a modular-add function ring_add(ptr, delay, NUM_SLOTS);
  - error bit index constants ERR_DUP=0, ERR_RANGE=1.
- One sub-module, spike_slot_ring:
  - the row storage with read-clear-on-advance and bit-set port;
  - rd_ptr and wrap logic.
- The top level handles range check, merge bypass, errors, the valid strobe and the optional counter.

Test Plan:
- Defaults, write {delay=3, axon=5}, then 4 tick_adv → axon_spikes bit5 = 1 only after the 4th, spikes_valid pulses 4×, earlier vectors 0.
- NUM_SLOTS=10, rd_ptr=8, write delay=5 → target row 3. After wrap, bit seen on the 6th tick_adv; error stays 0.
- Same packet {0, 7} written twice before a tick → error=2'b01, single bit7 delivered. err_clr → error=0.
- NUM_AXONS=200, write axon=250 → dropped, error[1]=1, no bit delivered in 16 ticks.
- wen {0, 9} in same cycle as tick_adv → axon_spikes bit9=1 next cycle, no duplicate error. The next tick delivers 0 for bit9.
- Load 3 spikes, assert flush together with wen and tick_adv → all rows 0, rd_ptr 0, no spikes_valid. With SCHED_PENDING_CNT_EN, pending_count=0.
